// File: rtl/gpu_pkg.sv
// Shared rasterizer back-end types: screen geometry, zbuffer address width, depth planes, sink states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpu_pkg;

    localparam int DEF_SCREEN_WIDTH  = 320;
    localparam int DEF_SCREEN_HEIGHT = 240;
    localparam int ZB_ADDR_W         = 17;
    localparam int FB_COLOR_W        = 16;

    // 1/z in 16.16: near plane at z=1, far plane at z=1024
    localparam logic signed [31:0] INV_NEAR_PLANE = 32'sh0001_0000;
    localparam logic signed [31:0] INV_FAR_PLANE  = 32'sh0000_0040;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // Framebuffer FIFO entry at the default colour width
    typedef struct packed {
        logic [ZB_ADDR_W-1:0]  addr;
        logic [FB_COLOR_W-1:0] color;
    } fb_entry_t;

endpackage

// File: rtl/point_fifo.sv
// Generic synchronous first-word-fall-through FIFO; DEPTH must be a power of two >= 2.
// Latency: a pushed word is visible on o_pop_dat the cycle after the push edge.
// Backpressure: o_full refuses pushes unless a pop happens in the same cycle; o_pop_dat holds until popped.
module point_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still takes a word when the head leaves in the same cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_pop_dat = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/zbuffer_point_sink.sv
// Point-stream sink: commits 1/z to the zbuffer, queues colour for the framebuffer, runs the per-frame clear sweep (CLEAR_FB_EN also clears the fb).
// Latency: zbuffer write and fb entry appear the cycle after the accepting edge; clear sweep takes W*H cycles (more with CLEAR_FB_EN under fb stalls).
// Backpressure: none upstream -- points arriving while clearing, off-screen, or with the fb FIFO full are dropped and flagged sticky on o_drop.
module zbuffer_point_sink
    import gpu_pkg::*;
#(
    parameter int                 SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int                 SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int                 COLOR_W       = 16,
    parameter int                 FIFO_DEPTH    = 4,
    parameter logic signed [31:0] CLEAR_DEPTH   = 32'sd0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_write,
    input  logic [31:0]          i_point,
    input  logic [31:0]          i_zdata,
    input  logic [COLOR_W-1:0]   i_color,
    input  logic                 i_clear,
    output logic                 o_busy,
    output logic                 o_zbuffer_we,
    output logic [ZB_ADDR_W-1:0] o_zbuffer_addr,
    output logic [31:0]          o_zbuffer_data,
    output logic                 o_fb_valid,
    input  logic                 i_fb_ready,
    output logic [ZB_ADDR_W-1:0] o_fb_addr,
    output logic [COLOR_W-1:0]   o_fb_data,
    output logic                 o_drop
);
    localparam int FB_W = ZB_ADDR_W + COLOR_W;
    localparam logic [ZB_ADDR_W-1:0] LAST_ADDR = ZB_ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);

    state_t               r_state;
    logic [ZB_ADDR_W-1:0] r_sweep_addr;
    logic                 r_zb_we;
    logic [ZB_ADDR_W-1:0] r_zb_addr;
    logic [31:0]          r_zb_data;
    logic                 r_drop;

    logic signed [15:0]   w_x;
    logic signed [15:0]   w_y;
    logic                 w_legal;
    logic [ZB_ADDR_W-1:0] w_pt_addr;
    logic                 w_fb_valid;
    logic                 w_fb_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_can_push;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_sweep_step;
    logic                 w_push;
    logic [FB_W-1:0]      w_push_dat;
    logic [FB_W-1:0]      w_head;

    // Coordinates are signed so negative values from clipped primitives fail the range test
    assign w_x       = i_point[15:0];
    assign w_y       = i_point[31:16];
    assign w_legal   = (w_x >= 16'sd0) && (int'(w_x) < SCREEN_WIDTH) &&
                       (w_y >= 16'sd0) && (int'(w_y) < SCREEN_HEIGHT);
    assign w_pt_addr = ZB_ADDR_W'(int'(w_y) * SCREEN_WIDTH + int'(w_x));

    assign w_fb_valid = !w_empty;
    assign w_fb_pop   = w_fb_valid && i_fb_ready;
    assign w_can_push = !w_full || w_fb_pop;
    assign w_accept   = (r_state == S_IDLE) && i_write && w_legal && w_can_push;
    assign w_drop     = i_write && !w_accept;

`ifdef CLEAR_FB_EN
    // Sweep shares the fb FIFO, so it only advances when its push lands
    assign w_sweep_step = (r_state == S_CLEAR) && w_can_push;
    assign w_push       = w_accept || w_sweep_step;
    assign w_push_dat   = w_sweep_step ? {r_sweep_addr, COLOR_W'(0)} : {w_pt_addr, i_color};
`else
    assign w_sweep_step = (r_state == S_CLEAR);
    assign w_push       = w_accept;
    assign w_push_dat   = {w_pt_addr, i_color};
`endif

    point_fifo #(
        .WIDTH (FB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_fb_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Sink FSM: point commits in S_IDLE, one clear write per step in S_CLEAR, sticky drop flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_sweep_addr <= '0;
            r_zb_we      <= 1'b0;
            r_zb_addr    <= '0;
            r_zb_data    <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_zb_we <= 1'b0;
            if (w_drop) r_drop <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_zb_we   <= 1'b1;
                        r_zb_addr <= w_pt_addr;
                        r_zb_data <= i_zdata;
                    end
                    if (i_clear) begin
                        r_state      <= S_CLEAR;
                        r_sweep_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    if (w_sweep_step) begin
                        r_zb_we   <= 1'b1;
                        r_zb_addr <= r_sweep_addr;
                        r_zb_data <= CLEAR_DEPTH;
                        if (r_sweep_addr == LAST_ADDR) r_state <= S_IDLE;
                        else                           r_sweep_addr <= r_sweep_addr + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy         = (r_state == S_CLEAR);
    assign o_zbuffer_we   = r_zb_we;
    assign o_zbuffer_addr = r_zb_addr;
    assign o_zbuffer_data = r_zb_data;
    assign o_fb_valid     = w_fb_valid;
    // Head is forced to zero when empty so the bus never shows stale or uninitialised storage
    assign o_fb_addr      = w_fb_valid ? w_head[FB_W-1:COLOR_W] : '0;
    assign o_fb_data      = w_fb_valid ? w_head[COLOR_W-1:0]    : '0;
    assign o_drop         = r_drop;

endmodule

// File: tb/tb_zbuffer_point_sink.sv
// Randomised scoreboard bench for zbuffer_point_sink (default build, zbuffer-only clear).
// Latency: expectations carry the cycle each zbuffer write must appear in.
// Backpressure: i_fb_ready is randomised; a monitor pops expected fb entries on each handshake.
module tb_zbuffer_point_sink;
    localparam int W     = 320;
    localparam int H     = 240;
    localparam int NPIX  = W * H;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_write;
    logic [31:0] i_point;
    logic [31:0] i_zdata;
    logic [15:0] i_color;
    logic        i_clear;
    logic        i_fb_ready;
    logic        o_busy;
    logic        o_zbuffer_we;
    logic [16:0] o_zbuffer_addr;
    logic [31:0] o_zbuffer_data;
    logic        o_fb_valid;
    logic [16:0] o_fb_addr;
    logic [15:0] o_fb_data;
    logic        o_drop;

    always #5 clk = ~clk;

    zbuffer_point_sink dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_write        (i_write),
        .i_point        (i_point),
        .i_zdata        (i_zdata),
        .i_color        (i_color),
        .i_clear        (i_clear),
        .o_busy         (o_busy),
        .o_zbuffer_we   (o_zbuffer_we),
        .o_zbuffer_addr (o_zbuffer_addr),
        .o_zbuffer_data (o_zbuffer_data),
        .o_fb_valid     (o_fb_valid),
        .i_fb_ready     (i_fb_ready),
        .o_fb_addr      (o_fb_addr),
        .o_fb_data      (o_fb_data),
        .o_drop         (o_drop)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } zexp_t;
    typedef struct { logic [31:0] addr; logic [31:0] color; } fexp_t;

    zexp_t zq[$];
    fexp_t fq[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    bit    mon_en = 1'b0;
    bit    clr_on = 1'b0;
    int    bs = 0;
    int    drop_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the sink is clearing during cycles bs .. bs+NPIX-1
    function automatic bit busy_at(input int c);
        return clr_on && (c >= bs) && (c < bs + NPIX);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of stimulus and record what the specification says must result
    task automatic step(input bit wr, input logic [15:0] y, input logic [15:0] x,
                        input logic [31:0] z, input logic [15:0] col,
                        input bit clr, input bit rdy);
        int  k;
        bit  idle;
        bit  pop;
        int  xs;
        int  ys;
        k    = cyc;
        idle = !busy_at(k);
        pop  = (fq.size() > 0) && rdy;
        i_write    = wr;
        i_point    = {y, x};
        i_zdata    = z;
        i_color    = col;
        i_clear    = clr;
        i_fb_ready = rdy;
        if (wr) begin
            xs = int'($signed(x));
            ys = int'($signed(y));
            if (idle && xs >= 0 && xs < W && ys >= 0 && ys < H &&
                (fq.size() < DEPTH || pop)) begin
                zq.push_back('{32'(ys * W + xs), z, k + 1});
                fq.push_back('{32'(ys * W + xs), 32'(col)});
            end else if (drop_cyc == 0) begin
                drop_cyc = k + 1;
            end
        end
        if (clr && idle) begin
            clr_on = 1'b1;
            bs     = k + 1;
            for (int a = 0; a < NPIX; a++) zq.push_back('{32'(a), 32'd0, k + 2 + a});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_xy(output logic [15:0] y, output logic [15:0] x);
        int r;
        r = $urandom_range(0, 7);
        if (r == 0)      x = 16'(W + $urandom_range(0, 40));
        else if (r == 1) x = 16'(16'hFFFF - $urandom_range(0, 20));
        else             x = 16'($urandom_range(0, W - 1));
        r = $urandom_range(0, 7);
        if (r == 0)      y = 16'(H + $urandom_range(0, 40));
        else if (r == 1) y = 16'(16'hFFFF - $urandom_range(0, 20));
        else             y = 16'($urandom_range(0, H - 1));
    endtask

    task automatic rand_step(input int wr_pct);
        logic [15:0] y;
        logic [15:0] x;
        rand_xy(y, x);
        step($urandom_range(0, 99) < wr_pct, y, x, $urandom, 16'($urandom),
             1'b0, 1'($urandom_range(0, 1)));
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues
    zexp_t       ze;
    fexp_t       fe;
    logic        prev_stall = 1'b0;
    logic [16:0] pa;
    logic [15:0] pd;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 64'(o_busy), 64'(busy_at(cyc)));
            chk("drop", 64'(o_drop), 64'(drop_cyc != 0 && cyc >= drop_cyc));
            if (o_zbuffer_we) begin
                if (zq.size() == 0) begin
                    chk("zb_unexpected_write", 64'(o_zbuffer_addr), 64'h1_0000_0000);
                end else begin
                    ze = zq.pop_front();
                    chk("zb_addr", 64'(o_zbuffer_addr), 64'(ze.addr));
                    chk("zb_data", 64'(o_zbuffer_data), 64'(ze.data));
                    chk("zb_cycle", 64'(cyc), 64'(ze.cyc));
                end
            end
            if (prev_stall) begin
                chk("fb_hold_valid", 64'(o_fb_valid), 64'd1);
                chk("fb_hold_addr", 64'(o_fb_addr), 64'(pa));
                chk("fb_hold_data", 64'(o_fb_data), 64'(pd));
            end
            if (o_fb_valid && i_fb_ready) begin
                if (fq.size() == 0) begin
                    chk("fb_unexpected_pop", 64'(o_fb_addr), 64'h1_0000_0000);
                end else begin
                    fe = fq.pop_front();
                    chk("fb_addr", 64'(o_fb_addr), 64'(fe.addr));
                    chk("fb_data", 64'(o_fb_data), 64'(fe.color));
                end
            end
            prev_stall = o_fb_valid && !i_fb_ready;
            pa = o_fb_addr;
            pd = o_fb_data;
        end
    end

    initial begin
        rst_n = 1'b0; i_write = 1'b0; i_point = '0; i_zdata = '0;
        i_color = '0; i_clear = 1'b0; i_fb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_zb_we", 64'(o_zbuffer_we), 64'd0);
        chk("rst_zb_addr", 64'(o_zbuffer_addr), 64'd0);
        chk("rst_fb_valid", 64'(o_fb_valid), 64'd0);
        chk("rst_fb_addr", 64'(o_fb_addr), 64'd0);
        chk("rst_drop", 64'(o_drop), 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // First point: {y=2,x=5} lands at 2*320+5 = 645 one cycle later
        step(1'b1, 16'd2, 16'd5, 32'h0001_0000, 16'h1234, 1'b0, 1'b1);
        chk("p0_zb_we", 64'(o_zbuffer_we), 64'd1);
        chk("p0_zb_addr", 64'(o_zbuffer_addr), 64'd645);
        chk("p0_zb_data", 64'(o_zbuffer_data), 64'h0001_0000);
        chk("p0_fb_valid", 64'(o_fb_valid), 64'd1);
        chk("p0_fb_addr", 64'(o_fb_addr), 64'd645);
        chk("p0_fb_data", 64'(o_fb_data), 64'h1234);
        repeat (3) step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);

        // Five points into a stalled 4-deep FIFO: the fifth is dropped
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("burst_no_drop_yet", 64'(o_drop), 64'd0);
            step(1'b1, 16'd1, 16'(10 + i), 32'(100 + i), 16'(16'hA000 + i), 1'b0, 1'b0);
        end
        chk("burst_drop", 64'(o_drop), 64'd1);
        chk("burst_no_zb_write", 64'(o_zbuffer_we), 64'd0);
        repeat (2) step(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (8) step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);

        // Off-screen points
        step(1'b1, 16'd0, 16'd320, 32'h55, 16'h1111, 1'b0, 1'b1);
        chk("illegal_x320_we", 64'(o_zbuffer_we), 64'd0);
        step(1'b1, 16'd3, 16'hFFFF, 32'h66, 16'h2222, 1'b0, 1'b1);
        chk("illegal_xneg_we", 64'(o_zbuffer_we), 64'd0);
        chk("illegal_fb_valid", 64'(o_fb_valid), 64'd0);

        // Random traffic with random backpressure
        repeat (400) rand_step(70);

        // Clear sweep with sporadic writes and repeated clear pulses
        step(1'b0, '0, '0, '0, '0, 1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < NPIX + 50 && (busy_at(cyc) || zq.size() > 0); i++) begin
            if ($urandom_range(0, 1023) == 0)
                step(1'b0, '0, '0, '0, '0, 1'b1, 1'($urandom_range(0, 1)));
            else
                rand_step(2);
        end
        chk("sweep_completed", 64'(zq.size()), 64'd0);

        repeat (200) rand_step(60);
        for (int i = 0; i < 100 && (fq.size() > 0 || zq.size() > 0); i++)
            step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        chk("queues_drained", 64'(fq.size() + zq.size()), 64'd0);

        // Reset while the sweep is at address 100
        mon_en = 1'b0;
        step(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
        repeat (100) step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        chk("midsweep_busy", 64'(o_busy), 64'd1);
        chk("midsweep_addr", 64'(o_zbuffer_addr), 64'd99);
        chk("midsweep_drop_set", 64'(o_drop), 64'd1);
        rst_n = 1'b0;
        step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_zb_we", 64'(o_zbuffer_we), 64'd0);
        chk("abort_fb_valid", 64'(o_fb_valid), 64'd0);
        chk("abort_drop", 64'(o_drop), 64'd0);
        rst_n = 1'b1;
        step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        chk("after_reset_idle", 64'(o_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
